// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219 receive-side model:
// register-map addresses and serial frame width.
package max7219_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

endpackage

// File: rtl/max7219_rx_shift.sv
// SPI receive front end: synchronisers, edge detection,
// 16-bit shift register and saturating bit counter.
module spi_rx_shift
    import max7219_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs,
    output logic        frame_done,
    output logic [15:0] frame_word,
    output logic        frame_short
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic [15:0]            shift_reg_q, shift_reg_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;

    logic       sclk_s, mosi_s, cs_s;
    logic       sclk_rise, cs_fall, cs_rise, shift_en;
    logic [4:0] cnt_base;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        sclk_rise   = sclk_s & ~sclk_prev_q;
        cs_fall     = ~cs_s & cs_prev_q;
        cs_rise     = cs_s & ~cs_prev_q;
        // An sclk edge coinciding with the cs rise still lands before the latch
        shift_en    = sclk_rise & (~cs_s | cs_rise);
        cnt_base    = cs_fall ? 5'd0 : bit_cnt_q;
        shift_reg_d = shift_reg_q;
        bit_cnt_d   = cnt_base;
        if (shift_en) begin
            shift_reg_d = {shift_reg_q[14:0], mosi_s};
            if (cnt_base < 5'(FRAME_BITS)) begin
                bit_cnt_d = cnt_base + 5'd1;
            end
        end
        frame_done  = cs_rise & (bit_cnt_d == 5'(FRAME_BITS));
        frame_short = cs_rise & (bit_cnt_d != 5'(FRAME_BITS));
        frame_word  = shift_reg_d;
    end

    // cs idles high so leaving reset with cs high is not seen as an edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            shift_reg_q <= '0;
            bit_cnt_q   <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            shift_reg_q <= shift_reg_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/max7219_rx.sv
// MAX7219 receive-side model: register file decoded from SPI
// frames plus a registered multiplexed row scanner.
module max7219_rx
    import max7219_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SCAN_DIV    = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs,
    output logic       frame_valid,
    output logic [3:0] frame_addr,
    output logic [7:0] frame_data,
    output logic       frame_err,
    output logic       shutdown_n,
    output logic [7:0] decode_mode,
    output logic [3:0] intensity,
    output logic [2:0] scan_limit,
    output logic       display_test,
    output logic [7:0] row_sel,
    output logic [7:0] row_data
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic        done, short_frame;
    logic [15:0] word;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic        unused_cmd;

    logic            valid_q, valid_d, err_q, err_d;
    logic [3:0]      addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic [7:0][7:0] digit_q, digit_d;
    logic [7:0]      decode_q, decode_d;
    logic [3:0]      inten_q, inten_d;
    logic [2:0]      limit_q, limit_d;
    logic            shdn_q, shdn_d;
    logic            test_q, test_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [2:0]      row_q, row_d;
    logic [7:0]      sel_q, sel_d;
    logic [7:0]      rdata_q, rdata_d;

    spi_rx_shift #(.SYNC_STAGES(SYNC_STAGES)) u_shift (
        .clk         (clk),
        .reset       (reset),
        .sclk        (sclk),
        .mosi        (mosi),
        .cs          (cs),
        .frame_done  (done),
        .frame_word  (word),
        .frame_short (short_frame)
    );

    assign addr       = word[11:8];
    assign data       = word[7:0];
    assign unused_cmd = ^word[15:12];

    always_comb begin
        valid_d  = done;
        err_d    = short_frame;
        addr_d   = addr_q;
        data_d   = data_q;
        digit_d  = digit_q;
        decode_d = decode_q;
        inten_d  = inten_q;
        limit_d  = limit_q;
        shdn_d   = shdn_q;
        test_d   = test_q;
        if (done) begin
            addr_d = addr;
            data_d = data;
            if (addr >= ADDR_DIGIT0 && addr <= ADDR_DIGIT7) begin
                digit_d[3'(addr - ADDR_DIGIT0)] = data;
            end
            case (addr)
                ADDR_DECODE:    decode_d = data;
                ADDR_INTENSITY: inten_d  = data[3:0];
                ADDR_SCANLIM:   limit_d  = data[2:0];
                ADDR_SHUTDOWN:  shdn_d   = data[0];
                ADDR_TEST:      test_d   = data[0];
                default:        ;
            endcase
        end
    end

    always_comb begin
        presc_d = presc_q + PW'(1);
        row_d   = row_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            // A shrunken scan limit sends the next advance back to row 0
            row_d   = (row_q >= limit_q) ? 3'd0 : row_q + 3'd1;
        end
        sel_d   = 8'd1 << row_q;
        rdata_d = digit_q[row_q];
        if (test_q) begin
            rdata_d = 8'hFF;
        end else if (!shdn_q) begin
            sel_d   = '0;
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            digit_q  <= '0;
            decode_q <= '0;
            inten_q  <= '0;
            limit_q  <= '0;
            shdn_q   <= 1'b0;
            test_q   <= 1'b0;
            presc_q  <= '0;
            row_q    <= '0;
            sel_q    <= '0;
            rdata_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            digit_q  <= digit_d;
            decode_q <= decode_d;
            inten_q  <= inten_d;
            limit_q  <= limit_d;
            shdn_q   <= shdn_d;
            test_q   <= test_d;
            presc_q  <= presc_d;
            row_q    <= row_d;
            sel_q    <= sel_d;
            rdata_q  <= rdata_d;
        end
    end

    assign frame_valid  = valid_q;
    assign frame_err    = err_q;
    assign frame_addr   = addr_q;
    assign frame_data   = data_q;
    assign decode_mode  = decode_q;
    assign intensity    = inten_q;
    assign scan_limit   = limit_q;
    assign shutdown_n   = shdn_q;
    assign display_test = test_q;
    assign row_sel      = sel_q;
    assign row_data     = rdata_q;

endmodule
